spi_peripheral_ht16d35a_rx: RTL and testbench
=============================================

# spi_peripheral_ht16d35a_rx

Receive-side peer for the HT16D35A-style 3-wire SPI link: samples `sck`/`dio`/`cs_n` in the system clock domain, shifts in bytes MSB-first on rising `sck`, and stores up to `OUT_BYTES` bytes per chip-select frame. Checks the ≥2 µs inter-byte `sck`-high gap and frame integrity. Used as an on-FPGA loopback target for the SPI controller and as a bench/board monitor of the display link.

## Interface
Parameters:
- `CLK_2us`, 100, clk cycles in 2 µs (50 MHz)
- `OUT_BYTES`, 8, max bytes stored per frame
- `OUT_BYTES_SZ`, `$clog2(OUT_BYTES)`, byte index width
- `SYNC_STAGES`, 2, synchronizer depth on `sck`, `dio`, `cs_n` (≥2)

Ports:
- `clk` in 1: system clock, only clock
- `reset_n` in 1: reset, synchronous, active-low
- `sck` in 1: serial clock from controller, idles high
- `dio` in 1: serial data from controller
- `cs_n` in 1: chip select, active low
- `rx_data` out 8×`OUT_BYTES`: bytes of current/last frame, index 0 = first byte
- `byte_data` out 8: most recently completed byte
- `byte_valid` out 1: one-cycle pulse per completed byte
- `byte_count` out `OUT_BYTES_SZ+1`: complete bytes in current/last frame (saturates at `OUT_BYTES`)
- `frame_done` out 1: one-cycle pulse at end of frame
- `busy` out 1: frame in progress
- `gap_error` out 1: sticky; inter-byte `sck`-high < `CLK_2us`
- `frame_error` out 1: sticky; `cs_n` rose mid-byte
- `overflow` out 1: sticky; more than `OUT_BYTES` bytes in frame

## Operation
- Inputs pass `SYNC_STAGES` flops; sync reset values `sck`=1, `cs_n`=1, `dio`=0. Edges detected on last stage vs. one further delayed copy.
- States: `S_WAIT_CS`, `S_IDLE`, `S_BITS`, `S_GAP`.
- `S_WAIT_CS` (entered on reset): wait until synced `cs_n`=1, then `S_IDLE`. Frame in progress at reset is ignored entirely.
- `S_IDLE`: on synced `cs_n` falling → clear `byte_count`, bit counter (7), `gap_error`, `frame_error`, `overflow`; `busy`←1; → `S_BITS`. `rx_data` retained until overwritten.
- `S_BITS`: each synced `sck` rising edge shifts synced `dio` into shift register (MSB first). On 8th bit: `byte_data`←byte, `byte_valid` pulse; if `byte_count` < `OUT_BYTES` store at `rx_data[byte_count]` and increment, else set `overflow` (byte_valid still pulses, nothing stored); clear gap counter; → `S_GAP`.
- `S_GAP`: gap counter increments each cycle while synced `sck`=1, saturating at `CLK_2us`. On `sck` falling edge: if counter < `CLK_2us` set `gap_error`; → `S_BITS` (bit counter 7). The byte is still received.
- Any state except `S_WAIT_CS`: synced `cs_n` rising → `frame_done` pulse, `busy`←0, → `S_IDLE`. If in `S_BITS` with 1–7 bits taken, set `frame_error`; partial bits discarded.
- Priority in one cycle: reset > `cs_n` rising > `sck` edge. `sck` edge coincident with `cs_n` rising is ignored.
- `sck` edges while `cs_n` high are ignored.

## Timing
- Reset values: `rx_data` all 0, `byte_data` 0, `byte_valid` 0, `byte_count` 0, `frame_done` 0, `busy` 0, `gap_error` 0, `frame_error` 0, `overflow` 0.
- Pin edge → internal edge detect: `SYNC_STAGES`+1 clk. `byte_valid`/`rx_data` write/`byte_count` update in the same cycle, 1 clk after detection of the 8th rising edge.
- `frame_done` asserted 1 clk after detection of `cs_n` rising; `byte_count`, flags final and stable from that cycle until next frame start.
- Supported input: each `sck` phase ≥ `SYNC_STAGES`+1 clk; `dio` stable across rising `sck`.
- Gap measured in clk cycles of synced `sck` high after the 8th rising edge; exactly `CLK_2us` cycles passes, `CLK_2us`−1 fails.
- Sticky flags clear only on reset or next frame start.

## Test plan
- Reset with `cs_n`=0 mid-frame, release, send 4 more bits, raise `cs_n` -> no `byte_valid`, no `frame_done`, all outputs at reset values; next full frame received normally.
- Frame 0xA5, 0x3C with 2 µs gaps, 8-clk half-bits -> two `byte_valid` pulses, `rx_data[0]`=0xA5, `rx_data[1]`=0x3C, `byte_count`=2, one `frame_done`, all flags 0.
- Two bytes with inter-byte `sck`-high of `CLK_2us`−1 clk -> `gap_error`=1, both bytes stored; repeat with exactly `CLK_2us` -> `gap_error`=0.
- 9 bytes 0x01..0x09 with `OUT_BYTES`=8 -> `byte_count`=8, `rx_data[7]`=0x08, `overflow`=1, 9 `byte_valid` pulses, last `byte_data`=0x09.
- One byte 0xFF then 3 bits and `cs_n` rise -> `frame_error`=1, `byte_count`=1, `frame_done` pulse; next frame clears `frame_error`.
- `sck` toggled 8 times with `cs_n` high -> no `byte_valid`, `busy` stays 0.

Source files
------------

// File: rtl/spi_peripheral_ht16d35a_rx.sv
// Receive-side peer for the HT16D35A-style 3-wire SPI link: synchronizes sck/dio/cs_n,
// assembles MSB-first bytes per chip-select frame and flags gap, framing and overflow faults.
module spi_peripheral_ht16d35a_rx #(
    parameter int CLK_2us      = 100,
    parameter int OUT_BYTES    = 8,
    parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES),
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sck,
    input  logic                        dio,
    input  logic                        cs_n,
    output logic [OUT_BYTES-1:0][7:0]   rx_data,
    output logic [7:0]                  byte_data,
    output logic                        byte_valid,
    output logic [OUT_BYTES_SZ:0]       byte_count,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        gap_error,
    output logic                        frame_error,
    output logic                        overflow
);
    localparam int GAP_W    = $clog2(CLK_2us + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [GAP_W-1:0]        GAP_MAX    = GAP_W'(CLK_2us);
    localparam logic [OUT_BYTES_SZ:0]   COUNT_MAX  = (OUT_BYTES_SZ + 1)'(OUT_BYTES);
    localparam logic [SETTLE_W-1:0]     SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);
    // Idle levels of the link, bit order {cs_n, dio, sck}
    localparam logic [2:0]              SYNC_RESET = 3'b101;

    typedef enum logic [1:0] {S_WAIT_CS, S_IDLE, S_BITS, S_GAP} state_t;

    logic [2:0] pins;
    logic [2:0] synced;
    assign pins = {cs_n, dio, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    chain_reg <= {SYNC_STAGES{SYNC_RESET[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
                end
            end
            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sck_s, dio_s, cs_s;
    logic sck_dly_reg, cs_dly_reg;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s = synced[0];
    assign dio_s = synced[1];
    assign cs_s  = synced[2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_dly_reg <= 1'b1;
            cs_dly_reg  <= 1'b1;
        end else begin
            sck_dly_reg <= sck_s;
            cs_dly_reg  <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_dly_reg;
    assign sck_fall = ~sck_s & sck_dly_reg;
    assign cs_rise  = cs_s & ~cs_dly_reg;
    assign cs_fall  = ~cs_s & cs_dly_reg;

    state_t              state_reg;
    logic [2:0]          bit_cnt_reg;
    logic [6:0]          shift_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic [7:0]          byte_next;

    assign byte_next = {shift_reg, dio_s};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_WAIT_CS;
            bit_cnt_reg <= 3'd7;
            shift_reg   <= '0;
            gap_cnt_reg <= '0;
            settle_reg  <= '0;
            rx_data     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            byte_count  <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            gap_error   <= 1'b0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            if (state_reg == S_WAIT_CS) begin
                // The synchronizer still holds its reset idle levels until flushed;
                // only trust cs_n once real pin samples reach the delayed copy.
                if (settle_reg != SETTLE_MAX) begin
                    settle_reg <= settle_reg + 1'b1;
                end else if (cs_s && cs_dly_reg) begin
                    state_reg <= S_IDLE;
                end
            end else if (cs_rise) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                if (state_reg == S_BITS && bit_cnt_reg != 3'd7) begin
                    frame_error <= 1'b1;
                end
                state_reg <= S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (cs_fall) begin
                            byte_count  <= '0;
                            bit_cnt_reg <= 3'd7;
                            gap_error   <= 1'b0;
                            frame_error <= 1'b0;
                            overflow    <= 1'b0;
                            busy        <= 1'b1;
                            state_reg   <= S_BITS;
                        end
                    end
                    S_BITS: begin
                        if (sck_rise) begin
                            shift_reg <= byte_next[6:0];
                            if (bit_cnt_reg == 3'd0) begin
                                byte_data  <= byte_next;
                                byte_valid <= 1'b1;
                                if (byte_count < COUNT_MAX) begin
                                    rx_data[byte_count[OUT_BYTES_SZ-1:0]] <= byte_next;
                                    byte_count <= byte_count + 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                                // The cycle the 8th edge is seen is already one high cycle of the gap
                                gap_cnt_reg <= GAP_W'(1);
                                state_reg   <= S_GAP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (sck_fall) begin
                            if (gap_cnt_reg < GAP_MAX) begin
                                gap_error <= 1'b1;
                            end
                            bit_cnt_reg <= 3'd7;
                            state_reg   <= S_BITS;
                        end else if (sck_s && gap_cnt_reg < GAP_MAX) begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= S_WAIT_CS;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_peripheral_ht16d35a_rx.sv
// Directed bench for spi_peripheral_ht16d35a_rx: frame vectors from a table plus
// hand-written reset-mid-frame and idle-sck sequences.
module tb_spi_peripheral_ht16d35a_rx;
    localparam int CLK_2US   = 100;
    localparam int OUT_BYTES = 8;
    localparam int OBS       = $clog2(OUT_BYTES);
    localparam int HALF      = 8;
    localparam int NVEC      = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sck = 1'b1;
    logic dio = 1'b0;
    logic cs_n = 1'b1;
    logic [OUT_BYTES-1:0][7:0] rx_data;
    logic [7:0] byte_data;
    logic byte_valid, frame_done, busy, gap_error, frame_error, overflow;
    logic [OBS:0] byte_count;

    int checks = 0;
    int errors = 0;
    int bv_total = 0;
    int fd_total = 0;

    typedef struct packed {
        logic [3:0]      nbytes;
        logic [9:0][7:0] data;
        logic [7:0]      gap;
        logic [2:0]      tail_bits;
        logic [3:0]      exp_count;
        logic [3:0]      exp_valid;
        logic            exp_gap;
        logic            exp_ferr;
        logic            exp_ovf;
        logic [7:0]      exp_last;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    spi_peripheral_ht16d35a_rx #(
        .CLK_2us(CLK_2US),
        .OUT_BYTES(OUT_BYTES),
        .OUT_BYTES_SZ(OBS),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sck(sck),
        .dio(dio),
        .cs_n(cs_n),
        .rx_data(rx_data),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_count(byte_count),
        .frame_done(frame_done),
        .busy(busy),
        .gap_error(gap_error),
        .frame_error(frame_error),
        .overflow(overflow)
    );

    always @(negedge clk) begin
        if (byte_valid) bv_total <= bv_total + 1;
        if (frame_done) fd_total <= fd_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [79:0] d, input int gap, input int tail,
                                input int cnt, input int nvalid, input logic g, input logic f,
                                input logic o, input logic [7:0] last);
        vec_t v;
        v.nbytes    = 4'(n);
        v.data      = d;
        v.gap       = 8'(gap);
        v.tail_bits = 3'(tail);
        v.exp_count = 4'(cnt);
        v.exp_valid = 4'(nvalid);
        v.exp_gap   = g;
        v.exp_ferr  = f;
        v.exp_ovf   = o;
        v.exp_last  = last;
        return v;
    endfunction

    // Send the top nbits of b MSB-first; the final high phase lasts last_high cycles
    task automatic send_bits(input logic [7:0] b, input int nbits, input int last_high);
        for (int i = 7; i >= 8 - nbits; i--) begin
            sck = 1'b0;
            dio = b[i];
            tick(HALF);
            sck = 1'b1;
            tick((i == 8 - nbits) ? last_high : HALF);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int bv0;
        int fd0;
        int hi;
        bv0 = bv_total;
        fd0 = fd_total;
        cs_n = 1'b0;
        tick(HALF);
        check($sformatf("v%0d busy_mid", idx), 64'(busy), 64'd1);
        for (int b = 0; b < int'(v.nbytes); b++) begin
            hi = (b == int'(v.nbytes) - 1 && v.tail_bits == 3'd0) ? 10 : int'(v.gap);
            send_bits(v.data[b], 8, hi);
        end
        if (v.tail_bits != 3'd0) send_bits(8'hA0, int'(v.tail_bits), 10);
        cs_n = 1'b1;
        tick(12);
        check($sformatf("v%0d byte_count", idx), 64'(byte_count), 64'(v.exp_count));
        check($sformatf("v%0d byte_valid_pulses", idx), 64'(bv_total - bv0), 64'(v.exp_valid));
        check($sformatf("v%0d frame_done_pulses", idx), 64'(fd_total - fd0), 64'd1);
        check($sformatf("v%0d gap_error", idx), 64'(gap_error), 64'(v.exp_gap));
        check($sformatf("v%0d frame_error", idx), 64'(frame_error), 64'(v.exp_ferr));
        check($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.exp_ovf));
        check($sformatf("v%0d byte_data", idx), 64'(byte_data), 64'(v.exp_last));
        check($sformatf("v%0d busy_end", idx), 64'(busy), 64'd0);
        for (int i = 0; i < int'(v.exp_count); i++) begin
            check($sformatf("v%0d rx_data[%0d]", idx, i), 64'(rx_data[i]), 64'(v.data[i]));
        end
        tick(10);
    endtask

    initial begin
        int bv0;
        int fd0;
        logic busy_seen;

        //            n  data (byte0 in low bits)           gap tail cnt val gap fe ov last
        vecs[0] = mk(2, 80'h3CA5,                           100, 0, 2, 2, 0, 0, 0, 8'h3C);
        vecs[1] = mk(2, 80'h3412,                            99, 0, 2, 2, 1, 0, 0, 8'h34);
        vecs[2] = mk(2, 80'h7856,                           100, 0, 2, 2, 0, 0, 0, 8'h78);
        vecs[3] = mk(9, 80'h090807060504030201,             100, 0, 8, 9, 0, 0, 1, 8'h09);
        vecs[4] = mk(1, 80'hFF,                             100, 3, 1, 1, 0, 1, 0, 8'hFF);
        vecs[5] = mk(1, 80'h81,                             100, 0, 1, 1, 0, 0, 0, 8'h81);

        tick(5);
        reset_n = 1'b1;
        tick(2);
        check("reset rx_data", 64'(rx_data), 64'd0);
        check("reset byte_data", 64'(byte_data), 64'd0);
        check("reset byte_valid", 64'(byte_valid), 64'd0);
        check("reset byte_count", 64'(byte_count), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset flags", 64'({gap_error, frame_error, overflow}), 64'd0);

        // Reset lands mid-frame; the rest of that frame must be ignored
        cs_n = 1'b0;
        tick(HALF);
        send_bits(8'hC0, 4, HALF);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        bv0 = bv_total;
        fd0 = fd_total;
        send_bits(8'h50, 4, 10);
        cs_n = 1'b1;
        tick(12);
        check("midrst byte_valid_pulses", 64'(bv_total - bv0), 64'd0);
        check("midrst frame_done_pulses", 64'(fd_total - fd0), 64'd0);
        check("midrst byte_count", 64'(byte_count), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst byte_data", 64'(byte_data), 64'd0);
        check("midrst rx_data", 64'(rx_data), 64'd0);
        check("midrst flags", 64'({gap_error, frame_error, overflow}), 64'd0);
        tick(10);

        for (int v = 0; v < NVEC; v++) begin
            run_frame(vecs[v], v);
        end

        // sck activity with chip select deasserted
        bv0 = bv_total;
        busy_seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            sck = ~sck;
            dio = ~dio;
            for (int c = 0; c < HALF; c++) begin
                tick(1);
                if (busy) busy_seen = 1'b1;
            end
        end
        tick(5);
        check("idle byte_valid_pulses", 64'(bv_total - bv0), 64'd0);
        check("idle busy", 64'(busy_seen), 64'd0);
        check("idle byte_count_kept", 64'(byte_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
